// File: rtl/phy_tx.sv
// phy_tx: AXI-Stream to GT TX framer with 8b/10b K-character
// delimiters (idle commas, start word, FD end-of-frame).
module phy_tx #(
  parameter int unsigned P_IDLE_MIN = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_tx_axis_data,
  input  logic [3:0]  i_tx_axis_keep,
  input  logic        i_tx_axis_valid,
  input  logic        i_tx_axis_last,
  output logic        o_tx_axis_ready,
  output logic [31:0] o_gt_tx_data,
  output logic [3:0]  o_gt_tx_char,
  output logic        o_tx_underrun
);

  localparam logic [7:0] K_BC = 8'hBC;
  localparam logic [7:0] D_50 = 8'h50;
  localparam logic [7:0] K_FB = 8'hFB;
  localparam logic [7:0] K_FD = 8'hFD;

  localparam logic [31:0] W_IDLE  = {K_BC, D_50, K_BC, D_50};
  localparam logic [31:0] W_START = {D_50, K_BC, D_50, K_FB};
  localparam logic [31:0] W_EOF   = {K_FD, K_BC, K_BC, K_BC};
  localparam logic [3:0]  C_IDLE  = 4'b1010;
  localparam logic [3:0]  C_START = 4'b0101;
  localparam logic [3:0]  C_EOF   = 4'b1111;

  localparam logic [7:0] IDLE_MIN = 8'(P_IDLE_MIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PAYLOAD,
    S_EOF,
    S_DROP
  } state_t;

  state_t      state_q;
  logic [7:0]  gap_q;
  logic [7:0]  gap_d;
  logic [31:0] word_q;
  logic [3:0]  char_q;
  logic        und_q;

  // saturating idle-gap count including the word being emitted now
  assign gap_d = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;

  // framing FSM; words are kept in logical (first-byte-high) order
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      gap_q   <= 8'd0;
      word_q  <= W_IDLE;
      char_q  <= C_IDLE;
      und_q   <= 1'b0;
    end else begin
      und_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          word_q <= W_IDLE;
          char_q <= C_IDLE;
          gap_q  <= gap_d;
          if (gap_d >= IDLE_MIN && i_tx_axis_valid)
            state_q <= S_START;
        end
        S_START: begin
          word_q  <= W_START;
          char_q  <= C_START;
          state_q <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (!i_tx_axis_valid) begin
            // gap mid-frame: close the frame now, rest of it is
            // still upstream and gets swallowed in DROP
            word_q  <= W_EOF;
            char_q  <= C_EOF;
            und_q   <= 1'b1;
            state_q <= S_DROP;
          end else if (!i_tx_axis_last) begin
            word_q <= i_tx_axis_data;
            char_q <= 4'b0000;
          end else begin
            case (i_tx_axis_keep)
              4'b1110: begin
                word_q  <= {i_tx_axis_data[31:8], K_FD};
                char_q  <= 4'b0001;
                state_q <= S_IDLE;
                gap_q   <= 8'd0;
              end
              4'b1100: begin
                word_q  <= {i_tx_axis_data[31:16], K_FD, K_BC};
                char_q  <= 4'b0011;
                state_q <= S_IDLE;
                gap_q   <= 8'd0;
              end
              4'b1000: begin
                word_q  <= {i_tx_axis_data[31:24], K_FD, K_BC, K_BC};
                char_q  <= 4'b0111;
                state_q <= S_IDLE;
                gap_q   <= 8'd0;
              end
              default: begin
                word_q  <= i_tx_axis_data;
                char_q  <= 4'b0000;
                state_q <= S_EOF;
              end
            endcase
          end
        end
        S_EOF: begin
          word_q  <= W_EOF;
          char_q  <= C_EOF;
          state_q <= S_IDLE;
          gap_q   <= 8'd0;
        end
        S_DROP: begin
          word_q <= W_IDLE;
          char_q <= C_IDLE;
          if (i_tx_axis_valid && i_tx_axis_last) begin
            state_q <= S_IDLE;
            gap_q   <= 8'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gap_q   <= 8'd0;
        end
      endcase
    end
  end

  assign o_tx_axis_ready = (state_q == S_PAYLOAD) || (state_q == S_DROP);

  assign o_gt_tx_data = {word_q[7:0], word_q[15:8],
                         word_q[23:16], word_q[31:24]};
  assign o_gt_tx_char = {char_q[0], char_q[1], char_q[2], char_q[3]};
  assign o_tx_underrun = und_q;

endmodule

// File: tb/tb_phy_tx.sv
// tb_phy_tx: directed vector bench for phy_tx.
// Two instances: P_IDLE_MIN = 2 (main) and 3 (back-to-back gap).
module tb_phy_tx;

  localparam logic [31:0] WI = 32'h50BC50BC;
  localparam logic [31:0] WS = 32'hFB50BC50;
  localparam logic [31:0] WE = 32'hBCBCBCFD;
  localparam logic [3:0]  CI = 4'b0101;
  localparam logic [3:0]  CS = 4'b1010;
  localparam logic [3:0]  CE = 4'b1111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_data;
  logic [3:0]  a_keep;
  logic        a_valid, a_last;
  logic        a_ready, a_un;
  logic [31:0] a_gd;
  logic [3:0]  a_gc;

  logic [31:0] b_data;
  logic [3:0]  b_keep;
  logic        b_valid, b_last;
  logic        b_ready, b_un;
  logic [31:0] b_gd;
  logic [3:0]  b_gc;

  phy_tx #(.P_IDLE_MIN(2)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_tx_axis_data(a_data), .i_tx_axis_keep(a_keep),
    .i_tx_axis_valid(a_valid), .i_tx_axis_last(a_last),
    .o_tx_axis_ready(a_ready),
    .o_gt_tx_data(a_gd), .o_gt_tx_char(a_gc),
    .o_tx_underrun(a_un)
  );

  phy_tx #(.P_IDLE_MIN(3)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_tx_axis_data(b_data), .i_tx_axis_keep(b_keep),
    .i_tx_axis_valid(b_valid), .i_tx_axis_last(b_last),
    .o_tx_axis_ready(b_ready),
    .o_gt_tx_data(b_gd), .o_gt_tx_char(b_gc),
    .o_tx_underrun(b_un)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic        l;
    logic [3:0]  k;
    logic [31:0] d;
    logic [31:0] ed;
    logic [3:0]  ec;
    logic        er;
    logic        eu;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic l, input logic [3:0] k,
                     input logic [31:0] d, input logic [31:0] ed,
                     input logic [3:0] ec, input logic er,
                     input logic eu);
    vec_t r;
    r = '{v, l, k, d, ed, ec, er, eu};
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cnt;
    int bidx;
    int gaps;
    bit counting;
    bit acc;
    bit seen_un;
    bit done;

    rst = 1'b1;
    a_data = '0; a_keep = 4'hF; a_valid = 1'b0; a_last = 1'b0;
    b_data = '0; b_keep = 4'hF; b_valid = 1'b0; b_last = 1'b0;

    // reset state
    #1;
    chk("rst data", a_gd, WI);
    chk("rst char", a_gc, CI);
    chk("rst ready", a_ready, 0);
    chk("rst underrun", a_un, 0);
    step;
    step;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk($sformatf("idle%0d data", i), a_gd, WI);
      chk($sformatf("idle%0d char", i), a_gc, CI);
      chk($sformatf("idle%0d ready", i), a_ready, 0);
    end

    // vector table, starts from fresh reset (gap = 0)
    add(1,0,4'hF,32'hAABBCCDD, WI,CI,0,0);
    add(1,0,4'hF,32'hAABBCCDD, WI,CI,0,0);
    add(1,0,4'hF,32'hAABBCCDD, WS,CS,1,0);
    add(1,0,4'hF,32'hAABBCCDD, 32'hDDCCBBAA,4'h0,1,0);
    add(1,0,4'hF,32'h11223344, 32'h44332211,4'h0,1,0);
    add(1,1,4'hF,32'h55667788, 32'h88776655,4'h0,0,0);
    add(1,1,4'hE,32'h0A0B0C0D, WE,CE,0,0);
    add(1,1,4'hE,32'h0A0B0C0D, WI,CI,0,0);
    add(1,1,4'hE,32'h0A0B0C0D, WI,CI,0,0);
    add(1,1,4'hE,32'h0A0B0C0D, WS,CS,1,0);
    add(1,1,4'hE,32'h0A0B0C0D, 32'hFD0C0B0A,4'b1000,0,0);
    add(1,1,4'hC,32'h0A0B0C0D, WI,CI,0,0);
    add(1,1,4'hC,32'h0A0B0C0D, WI,CI,0,0);
    add(1,1,4'hC,32'h0A0B0C0D, WS,CS,1,0);
    add(1,1,4'hC,32'h0A0B0C0D, 32'hBCFD0B0A,4'b1100,0,0);
    add(1,1,4'h8,32'h0A0B0C0D, WI,CI,0,0);
    add(1,1,4'h8,32'h0A0B0C0D, WI,CI,0,0);
    add(1,1,4'h8,32'h0A0B0C0D, WS,CS,1,0);
    add(1,1,4'h8,32'h0A0B0C0D, 32'hBCBCFD0A,4'b1110,0,0);
    add(1,0,4'hF,32'h11111111, WI,CI,0,0);
    add(1,0,4'hF,32'h11111111, WI,CI,0,0);
    add(1,0,4'hF,32'h11111111, WS,CS,1,0);
    add(1,0,4'hF,32'h11111111, 32'h11111111,4'h0,1,0);
    add(0,0,4'hF,32'h00000000, WE,CE,1,1);
    add(1,0,4'hF,32'h22222222, WI,CI,1,0);
    add(1,0,4'hF,32'h33333333, WI,CI,1,0);
    add(1,1,4'hF,32'h44444444, WI,CI,0,0);
    add(0,0,4'hF,32'h00000000, WI,CI,0,0);
    add(0,0,4'hF,32'h00000000, WI,CI,0,0);
    add(1,0,4'hF,32'hAAAAAAAA, WI,CI,0,0);
    add(0,0,4'hF,32'h00000000, WS,CS,1,0);
    add(0,0,4'hF,32'h00000000, WE,CE,1,1);
    add(1,1,4'hF,32'hBBBBBBBB, WI,CI,0,0);
    add(1,1,4'h6,32'h12345678, WI,CI,0,0);
    add(1,1,4'h6,32'h12345678, WI,CI,0,0);
    add(1,1,4'h6,32'h12345678, WS,CS,1,0);
    add(1,1,4'h6,32'h12345678, 32'h78563412,4'h0,0,0);
    add(0,0,4'hF,32'h00000000, WE,CE,0,0);
    add(0,0,4'hF,32'h00000000, WI,CI,0,0);

    do_reset;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t r;
      r = tbl[i];
      a_valid = r.v;
      a_last  = r.l;
      a_keep  = r.k;
      a_data  = r.d;
      step;
      chk($sformatf("row%0d data", i), a_gd, r.ed);
      chk($sformatf("row%0d char", i), a_gc, r.ec);
      chk($sformatf("row%0d ready", i), a_ready, r.er);
      chk($sformatf("row%0d underrun", i), a_un, r.eu);
    end

    // reset in the middle of a payload
    a_valid = 1'b1; a_last = 1'b0; a_keep = 4'hF;
    a_data = 32'hCAFE0001;
    for (int i = 0; i < 4; i++) step;
    chk("mid payload ready", a_ready, 1);
    chk("mid payload data", a_gd, 32'h0100FECA);
    rst = 1'b1;
    #1;
    chk("mid rst data", a_gd, WI);
    chk("mid rst char", a_gc, CI);
    chk("mid rst ready", a_ready, 0);
    rst = 1'b0;
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step;
      if (a_gd == WS && a_gc == CS) done = 1'b1;
      else if (a_gd == WI && a_gc == CI) cnt++;
    end
    chk("post rst start seen", done, 1);
    chk("post rst idle count", cnt, 2);
    a_last = 1'b1;
    step;
    chk("post rst beat", a_gd, 32'h0100FECA);
    a_valid = 1'b0;
    step;
    chk("post rst eof data", a_gd, WE);
    chk("post rst eof char", a_gc, CE);

    // back-to-back 2-beat frames, P_IDLE_MIN = 3
    bidx = 0;
    gaps = 0;
    counting = 1'b0;
    seen_un = 1'b0;
    cnt = 0;
    b_valid = 1'b1; b_data = 0; b_last = 1'b0;
    for (int i = 0; i < 200 && gaps < 2; i++) begin
      acc = b_valid && b_ready;
      step;
      if (acc) begin
        bidx++;
        b_data = bidx;
        b_last = bidx[0];
      end
      if (b_un) seen_un = 1'b1;
      if (b_gd == WE && b_gc == CE) begin
        counting = 1'b1;
        cnt = 0;
      end else if (counting && b_gd == WI && b_gc == CI) begin
        cnt++;
      end else if (counting && b_gd == WS && b_gc == CS) begin
        chk($sformatf("b2b gap%0d", gaps), cnt, 3);
        counting = 1'b0;
        gaps++;
      end
    end
    chk("b2b gaps seen", gaps, 2);
    chk("b2b no underrun", seen_un, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
